// File: rtl/lookup_pkg.sv
// Shared definitions for the next-hop fetch stage.
//   ADDR_W/DATA_W/NH_W : DRAM row address, row and next-hop entry widths
//   QDEPTH             : request queue depth (power of 2)
//   TIMEOUT_CYC        : WAIT cycles before a timeout result (DRAM_TIMEOUT_EN builds only)
//   fetch_state_t      : fetch FSM states
//   req_entry_t        : one queued request {row address, entry offset}
//   nh_select()        : picks one next-hop entry out of a DRAM row
package lookup_pkg;

  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 32;
  localparam int NH_W        = 8;
  localparam int QDEPTH      = 2;
  localparam int TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        offset;
  } req_entry_t;

  // Entries are packed MSB-first to match the trie bit order:
  // offset 0 is the top byte of the row, offset 3 the bottom byte.
  function automatic logic [NH_W-1:0] nh_select(input logic [DATA_W-1:0] row,
                                                input logic [1:0]        offset);
    logic [NH_W-1:0] sel;
    case (offset)
      2'd0:    sel = row[DATA_W-1        -: NH_W];
      2'd1:    sel = row[DATA_W-1-NH_W   -: NH_W];
      2'd2:    sel = row[DATA_W-1-2*NH_W -: NH_W];
      default: sel = row[DATA_W-1-3*NH_W -: NH_W];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/nh_req_fifo.sv
// Circular request queue of req_entry_t.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : entry to enqueue
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry
//   count_o       : registered occupancy, 0..DEPTH
//   full_o/empty_o: derived from the registered occupancy
module nh_req_fifo
  import lookup_pkg::*;
#(
  parameter  int DEPTH = QDEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  req_entry_t       push_data_i,
  input  logic             pop_i,
  output req_entry_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  req_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: count_q decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // DEPTH is a power of 2, so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nexthop_fetch.sv
// Next-hop fetch stage: queues finished trie traversals, reads the DRAM row
// for each over a req/ack port and presents the selected 8-bit entry on a
// valid/ready output. Decouples DRAM latency from the traversal engine.
//   clock_i, reset_i   : clock, asynchronous active-high reset
//   lookup_done_i      : strobe with dram_address_i/offset_i valid
//   in_ready_o         : queue not full (dropped strobes set ovf_sticky_o)
//   dram_req_o/addr_o  : read request, address held while dram_req_o=1
//   dram_ack_i         : request accepted (only looked at in REQ)
//   dram_rvalid_i/rdata: read data (only looked at in WAIT)
//   nh_valid_o/data_o  : next-hop result; nh_error_o flags a timeout result
//   nh_ready_i         : consumer accepts the result
//   ovf_sticky_o       : a lookup was dropped since reset
//   state_o            : current FSM state (debug)
// Handshake: the result transfers on the cycle where nh_valid_o && nh_ready_i;
// nh_data_o/nh_error_o hold stable while nh_valid_o is high and not accepted.
// Build option: define DRAM_TIMEOUT_EN to add a WAIT-state timeout that
// produces an error result after TIMEOUT_CYC cycles with no read data.
module nexthop_fetch
  import lookup_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              lookup_done_i,
  input  logic [ADDR_W-1:0] dram_address_i,
  input  logic [1:0]        offset_i,
  output logic              in_ready_o,
  output logic              dram_req_o,
  output logic [ADDR_W-1:0] dram_addr_o,
  input  logic              dram_ack_i,
  input  logic              dram_rvalid_i,
  input  logic [DATA_W-1:0] dram_rdata_i,
  output logic              nh_valid_o,
  output logic [NH_W-1:0]   nh_data_o,
  output logic              nh_error_o,
  input  logic              nh_ready_i,
  output logic              ovf_sticky_o,
  output logic [1:0]        state_o
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetch_state_t     state_q;
  logic [NH_W-1:0]  nh_data_q;
  logic             ovf_q;
  logic             ready_en_q;
  req_entry_t       push_entry;
  req_entry_t       head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_ok;
  logic             pop;
  logic             more_after_pop;

  // ready_en_q keeps in_ready low while in reset so every output reads 0.
  assign push_ok    = lookup_done_i && ready_en_q && !fifo_full;
  assign pop        = (state_q == HOLD) && nh_ready_i;
  assign push_entry = '{addr: dram_address_i, offset: offset_i};
  // Occupancy after this cycle's pop, including a same-cycle push.
  assign more_after_pop = (fifo_count > CNT_W'(1)) || push_ok;

  nh_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .push_i      (push_ok),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef DRAM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_q;
  logic             nh_error_q;
  assign nh_error_o = nh_error_q;
`else
  assign nh_error_o = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      nh_data_q  <= '0;
      ovf_q      <= 1'b0;
      ready_en_q <= 1'b0;
`ifdef DRAM_TIMEOUT_EN
      tmo_q      <= '0;
      nh_error_q <= 1'b0;
`endif
    end else begin
      ready_en_q <= 1'b1;
      if (lookup_done_i && !(ready_en_q && !fifo_full)) ovf_q <= 1'b1;
      case (state_q)
        // Leaving IDLE on the push itself gives dram_req the cycle after the push.
        IDLE: if (!fifo_empty || push_ok) state_q <= REQ;
        REQ: begin
          if (dram_ack_i) begin
            state_q <= WAIT;
`ifdef DRAM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        WAIT: begin
          if (dram_rvalid_i) begin
            nh_data_q  <= nh_select(dram_rdata_i, head.offset);
            state_q    <= HOLD;
`ifdef DRAM_TIMEOUT_EN
            nh_error_q <= 1'b0;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            nh_data_q  <= '0;
            nh_error_q <= 1'b1;
            state_q    <= HOLD;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
`endif
          end
        end
        HOLD: begin
          if (nh_ready_i) begin
            nh_data_q <= '0;
`ifdef DRAM_TIMEOUT_EN
            nh_error_q <= 1'b0;
`endif
            state_q <= more_after_pop ? REQ : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o   = ready_en_q && !fifo_full;
  assign dram_req_o   = (state_q == REQ);
  assign dram_addr_o  = (state_q == REQ) ? head.addr : '0;
  assign nh_valid_o   = (state_q == HOLD);
  assign nh_data_o    = nh_data_q;
  assign ovf_sticky_o = ovf_q;
  assign state_o      = state_q;

endmodule
